// File: rtl/arp_cache_pkg.sv
// Shared types and constants for the aged ARP cache: FSM state encoding,
// address widths and the broadcast IP/MAC pair.
package arp_cache_pkg;

  localparam int IP_W  = 32;
  localparam int MAC_W = 48;

  localparam logic [IP_W-1:0]  BCAST_IP  = 32'hFFFF_FFFF;
  localparam logic [MAC_W-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEEK     = 3'd1,
    SEEK_RSP = 3'd2,
    UPD_SCAN = 3'd3,
    UPD_WR   = 3'd4
  } arp_state_e;

  typedef struct packed {
    logic [IP_W-1:0]  ip;
    logic [MAC_W-1:0] mac;
  } arp_pair_t;

endpackage

// File: rtl/arp_cache_aged_if.sv
// Client-side bundle of the ARP cache: lookup handshake, miss request,
// learned-address updates, flush and occupancy.
interface arp_cache_aged_if #(
  parameter int P_DEPTH = 8
);
  import arp_cache_pkg::*;

  localparam int CNT_W = $clog2(P_DEPTH + 1);

  logic [IP_W-1:0]  i_seek_ip;
  logic             i_seek_valid;
  logic             o_seek_ready;
  logic [MAC_W-1:0] o_seek_mac;
  logic             o_seek_hit;
  logic             o_seek_valid;
  logic [IP_W-1:0]  o_arp_req_ip;
  logic             o_arp_req_valid;
  logic [IP_W-1:0]  i_updata_ip;
  logic [MAC_W-1:0] i_updata_mac;
  logic             i_updata_valid;
  logic             o_upd_drop;
  logic             i_flush;
  logic [CNT_W-1:0] o_entry_count;

  modport master (
    output i_seek_ip, i_seek_valid, i_updata_ip, i_updata_mac, i_updata_valid, i_flush,
    input  o_seek_ready, o_seek_mac, o_seek_hit, o_seek_valid,
           o_arp_req_ip, o_arp_req_valid, o_upd_drop, o_entry_count
  );

  modport slave (
    input  i_seek_ip, i_seek_valid, i_updata_ip, i_updata_mac, i_updata_valid, i_flush,
    output o_seek_ready, o_seek_mac, o_seek_hit, o_seek_valid,
           o_arp_req_ip, o_arp_req_valid, o_upd_drop, o_entry_count
  );

endinterface

// File: rtl/arp_age_ticker.sv
// Free-running prescaler: one-cycle tick every P_TICK_DIV clocks, used as
// the time base for entry aging.
module arp_age_ticker #(
  parameter int P_TICK_DIV = 125000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic tick
);

  localparam int              CW   = $clog2(P_TICK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(P_TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (cnt_q == LAST);
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/arp_cache_aged.sv
// P_DEPTH-entry IP->MAC cache with per-entry aging. Lookups and updates both
// walk the table one entry per clock; a miss raises a request toward ARP_TX.
module arp_cache_aged
  import arp_cache_pkg::*;
#(
  parameter int P_DEPTH    = 8,
  parameter int P_TICK_DIV = 125000,
  parameter int P_MAX_AGE  = 300,
  parameter int P_AGE_W    = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  arp_cache_aged_if.slave bus
);

  localparam int                 IDX_W    = $clog2(P_DEPTH);
  localparam int                 CNT_W    = $clog2(P_DEPTH + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(P_DEPTH - 1);
  localparam logic [P_AGE_W-1:0] MAX_AGE  = P_AGE_W'(P_MAX_AGE);
  localparam logic [P_AGE_W-1:0] AGE_SAT  = '1;

  // Table storage
  logic [P_DEPTH-1:0] vld_q;
  logic [IP_W-1:0]    ip_q  [P_DEPTH];
  logic [MAC_W-1:0]   mac_q [P_DEPTH];
  logic [P_AGE_W-1:0] age_q [P_DEPTH];
  logic [P_AGE_W-1:0] age_inc [P_DEPTH];

  // Control
  arp_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             scan_last;
  logic             seek_go, upd_go;
  logic             tick;

  logic [IP_W-1:0]  seek_ip_q;
  logic             found_q;
  logic [MAC_W-1:0] found_mac_q;

  logic             pend_vld_q, pend_vld_d;
  arp_pair_t        pend_q, pend_d;
  arp_pair_t        work_q;

  logic             match_found_q, free_found_q;
  logic [IDX_W-1:0] match_idx_q, free_idx_q, old_idx_q;
  logic [P_AGE_W-1:0] old_age_q;
  logic [IDX_W-1:0] victim;

  logic             ready_d;
  logic [CNT_W-1:0] cnt_d;

  arp_age_ticker #(.P_TICK_DIV(P_TICK_DIV)) u_ticker (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .tick  (tick)
  );

  assign scan_last = (idx_q == LAST_IDX);
  assign victim    = match_found_q ? match_idx_q :
                     free_found_q  ? free_idx_q  : old_idx_q;

  // NOTE: every variable gets a default at the top of each always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    seek_go = 1'b0;
    upd_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_seek_valid && bus.o_seek_ready) begin
          seek_go = 1'b1;
          state_d = SEEK;
        end else if (pend_vld_q || bus.i_updata_valid) begin
          upd_go  = 1'b1;
          state_d = UPD_SCAN;
        end
      end
      SEEK:     if (scan_last) state_d = SEEK_RSP;
      SEEK_RSP: state_d = IDLE;
      UPD_SCAN: if (scan_last) state_d = UPD_WR;
      UPD_WR:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (bus.i_flush) state_d = IDLE;
  end

  // The pending slot is emptied when IDLE hands its contents to the scan.
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    if (bus.i_updata_valid) begin
      pend_vld_d = 1'b1;
      pend_d     = '{ip: bus.i_updata_ip, mac: bus.i_updata_mac};
    end
    if (upd_go)      pend_vld_d = 1'b0;
    if (bus.i_flush) pend_vld_d = 1'b0;
  end

  assign ready_d = (state_d == IDLE) && !pend_vld_d;

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < P_DEPTH; i++) cnt_d = cnt_d + CNT_W'(vld_q[i]);
  end

  always_comb begin
    for (int i = 0; i < P_DEPTH; i++)
      age_inc[i] = (age_q[i] == AGE_SAT) ? age_q[i] : age_q[i] + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q             <= IDLE;
      idx_q               <= '0;
      seek_ip_q           <= '0;
      found_q             <= 1'b0;
      found_mac_q         <= '0;
      pend_vld_q          <= 1'b0;
      pend_q              <= '0;
      work_q              <= '0;
      match_found_q       <= 1'b0;
      free_found_q        <= 1'b0;
      match_idx_q         <= '0;
      free_idx_q          <= '0;
      old_idx_q           <= '0;
      old_age_q           <= '0;
      bus.o_seek_ready    <= 1'b0;
      bus.o_seek_valid    <= 1'b0;
      bus.o_seek_hit      <= 1'b0;
      bus.o_seek_mac      <= '0;
      bus.o_arp_req_valid <= 1'b0;
      bus.o_arp_req_ip    <= '0;
      bus.o_upd_drop      <= 1'b0;
      bus.o_entry_count   <= '0;
    end else begin
      state_q             <= state_d;
      pend_vld_q          <= pend_vld_d;
      pend_q              <= pend_d;
      bus.o_seek_ready    <= ready_d;
      bus.o_entry_count   <= cnt_d;
      bus.o_upd_drop      <= bus.i_updata_valid && pend_vld_q && !bus.i_flush;
      bus.o_seek_valid    <= 1'b0;
      bus.o_seek_hit      <= 1'b0;
      bus.o_seek_mac      <= '0;
      bus.o_arp_req_valid <= 1'b0;
      bus.o_arp_req_ip    <= '0;
      if (!bus.i_flush) begin
        case (state_q)
          IDLE: begin
            idx_q <= '0;
            if (seek_go) begin
              seek_ip_q   <= bus.i_seek_ip;
              found_q     <= 1'b0;
              found_mac_q <= '0;
            end else if (upd_go) begin
              work_q        <= bus.i_updata_valid ?
                               arp_pair_t'{ip: bus.i_updata_ip, mac: bus.i_updata_mac} : pend_q;
              match_found_q <= 1'b0;
              free_found_q  <= 1'b0;
              old_idx_q     <= '0;
              old_age_q     <= '0;
            end
          end
          SEEK: begin
            if (!found_q && vld_q[idx_q] && (ip_q[idx_q] == seek_ip_q)) begin
              found_q     <= 1'b1;
              found_mac_q <= mac_q[idx_q];
            end
            if (!scan_last) idx_q <= idx_q + 1'b1;
          end
          SEEK_RSP: begin
            bus.o_seek_valid <= 1'b1;
            if (seek_ip_q == BCAST_IP) begin
              bus.o_seek_hit <= 1'b1;
              bus.o_seek_mac <= BCAST_MAC;
            end else if (found_q) begin
              bus.o_seek_hit <= 1'b1;
              bus.o_seek_mac <= found_mac_q;
            end else begin
              bus.o_arp_req_valid <= 1'b1;
              bus.o_arp_req_ip    <= seek_ip_q;
            end
          end
          UPD_SCAN: begin
            if (vld_q[idx_q]) begin
              if (!match_found_q && (ip_q[idx_q] == work_q.ip)) begin
                match_found_q <= 1'b1;
                match_idx_q   <= idx_q;
              end
              // Strict compare keeps the lowest index among equally old entries.
              if (age_q[idx_q] > old_age_q) begin
                old_age_q <= age_q[idx_q];
                old_idx_q <= idx_q;
              end
            end else if (!free_found_q) begin
              free_found_q <= 1'b1;
              free_idx_q   <= idx_q;
            end
            if (!scan_last) idx_q <= idx_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Aging and the UPD_WR write share one block so the write overrides a
  // coincident tick on the same entry.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld_q <= '0;
      for (int i = 0; i < P_DEPTH; i++) age_q[i] <= '0;
    end else if (bus.i_flush) begin
      vld_q <= '0;
    end else begin
      for (int i = 0; i < P_DEPTH; i++) begin
        if (tick && vld_q[i]) begin
          age_q[i] <= age_inc[i];
          if (age_inc[i] >= MAX_AGE) vld_q[i] <= 1'b0;
        end
        if ((state_q == UPD_WR) && (victim == IDX_W'(i))) begin
          vld_q[i] <= 1'b1;
          age_q[i] <= '0;
        end
      end
    end
  end

  // NOTE: the ip/mac arrays are deliberately left out of reset; vld_q
  // qualifies every read, so resetting the payload would only add reset fanout.
  always_ff @(posedge i_clk) begin
    if ((state_q == UPD_WR) && !bus.i_flush) begin
      ip_q[victim]  <= work_q.ip;
      mac_q[victim] <= work_q.mac;
    end
  end

endmodule

// File: doc/arp_cache_aged.md
Name: arp_cache_aged

Overview:
- Parametrised successor to the single-entry ARP lookup table: P_DEPTH-entry IP->MAC cache with per-entry aging, expiry and replacement.
- Sits between ARP_RX (updates), the IP/UDP TX path (lookups) and ARP_TX (request triggering on a miss).
- Lookups use a valid/ready handshake, have fixed latency, and return hit/miss.
- On a miss, the block pulses a request so ARP_TX can send an ARP request for the unresolved IP.

Parameters:
- P_DEPTH, 8, number of cache entries; power of two, 2..64.
- P_TICK_DIV, 125000, i_clk cycles per age tick (1 ms at 125 MHz); >= 2.
- P_MAX_AGE, 300, ticks after the last refresh at which an entry expires; 1..2^P_AGE_W-1.
- P_AGE_W, 16, width of each per-entry age counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_seek_ip  in  32  IP address to resolve.
- i_seek_valid  in  1  lookup request.
- o_seek_ready  out  1  lookup can be accepted.
- o_seek_mac  out  48  resolved MAC; 0 on a miss.
- o_seek_hit  out  1  qualifies o_seek_mac.
- o_seek_valid  out  1  one-cycle result strobe.
- o_arp_req_ip  out  32  IP to request on a miss.
- o_arp_req_valid  out  1  one-cycle miss strobe to ARP_TX.
- i_updata_ip  in  32  learned IP from ARP_RX.
- i_updata_mac  in  48  learned MAC from ARP_RX.
- i_updata_valid  in  1  one-cycle update pulse.
- o_upd_drop  out  1  one-cycle pulse: pending update overwritten.
- i_flush  in  1  invalidate all entries.
- o_entry_count  out  $clog2(P_DEPTH+1)  number of valid entries.

Behaviour:
- Reset (i_rst=0, async):
  - All entries invalid; all outputs 0, including o_seek_ready.
  - FSM in IDLE; pending-update register empty; tick prescaler cleared.
- Storage: per entry, vld, ip[31:0], mac[47:0], age[P_AGE_W-1:0], held in registers.
- FSM states and transitions:
  - IDLE -> SEEK on a seek handshake, or -> UPD_SCAN if an update is pending or arriving.
  - SEEK scans index 0..P_DEPTH-1 at one entry per cycle, then -> SEEK_RSP.
  - SEEK_RSP -> IDLE.
  - UPD_SCAN scans P_DEPTH cycles, then -> UPD_WR.
  - UPD_WR -> IDLE.
- Handshake:
  - o_seek_ready is registered and is 1 only in IDLE with no pending update.
  - A seek is accepted when i_seek_valid & o_seek_ready; the IP is latched.
- Seek latency: o_seek_valid is asserted exactly P_DEPTH+1 cycles after the acceptance edge, for 1 cycle.
  - Hit: o_seek_hit=1 and o_seek_mac = the lowest-index valid entry whose ip matches.
  - Miss: o_seek_hit=0, o_seek_mac=0, and in the same cycle o_arp_req_valid=1 with o_arp_req_ip = the seek IP.
  - Broadcast seek (32'hFFFFFFFF) always hits with MAC 48'hFFFFFFFFFFFF at the same latency, and never raises a request.
- Updates:
  - i_updata_valid is latched into the pending register in any state.
  - If the pending register is already full, the new update overwrites it and o_upd_drop pulses.
  - A seek accepted in the same cycle as an update wins; the update waits in pending.
  - Pending updates are served on the next IDLE, before any new seek.
- Replacement choice (resolved at the end of UPD_SCAN), in priority order:
  - Valid entry with matching ip: refresh its mac and set age=0.
  - Otherwise, the lowest-index invalid entry.
  - Otherwise, the entry with the largest age, lowest index on a tie.
  - UPD_WR writes vld=1, ip, mac, age=0.
- Aging:
  - The prescaler emits a tick every P_TICK_DIV cycles.
  - On a tick, every valid entry's age increments, saturating.
  - An entry with age >= P_MAX_AGE is cleared to vld=0 on that same tick.
  - A write in UPD_WR coinciding with a tick on the same entry: the write wins (age=0, vld=1).
  - An entry expiring during a seek scan is checked with its vld value at the cycle it is scanned.
- Flush:
  - i_flush=1 clears all vld and the pending register on the next edge and forces IDLE.
  - An in-flight seek or update is aborted with no o_seek_valid and no o_arp_req_valid.
  - Flush has priority over updates, aging and seeks in the same cycle.
- o_entry_count is registered; it reflects table changes 1 cycle after they occur.
- Width rules:
  - The scan index is $clog2(P_DEPTH) bits and must not wrap before terminal detection.
  - The age compare is unsigned.

Decomposition:
- Package arp_cache_pkg holds:
  - the FSM state enum (IDLE, SEEK, SEEK_RSP, UPD_SCAN, UPD_WR);
  - BCAST_IP and BCAST_MAC constants;
  - IP_W=32 and MAC_W=48.
- One sub-module, arp_age_ticker: P_TICK_DIV prescaler producing a 1-cycle tick, cleared by reset.

Test Plan:
- Insert 192.168.10.5 / 00:11:22:33:44:55, then seek 192.168.10.5 -> o_seek_valid exactly 9 cycles after acceptance (P_DEPTH=8), hit=1, MAC 00:11:22:33:44:55, no request.
- Seek unknown 192.168.10.9 -> hit=0, mac=0, o_arp_req_valid=1 with ip C0A80A09 in the same cycle; seek 255.255.255.255 -> hit with FF..FF and no request.
- Fill 8 entries; age entry 3 longest (refresh the others); insert a 9th IP -> it lands in index 3 and the old IP in entry 3 now misses; re-insert an existing IP with a new MAC -> refreshed in place, o_entry_count stays 8.
- P_TICK_DIV=4, P_MAX_AGE=3: insert, idle 12 cycles -> entry invalid, seek misses, o_entry_count drops 1->0.
- Seek accepted and update pulsed in the same cycle, then a second update pulsed during the scan -> seek result unaffected, o_upd_drop=1 once, only the second update is written.
- Assert i_flush mid-seek -> no o_seek_valid and o_entry_count=0 next cycle; assert i_rst low mid-update -> all outputs 0 immediately (async).
